lsu: RTL and testbench
======================

# lsu

Load/store unit for the P6 pipeline: the initiator side of the data-memory port. Accepts one load or store request per transaction from the MEM stage and checks alignment. Generates the byte-enable, replicated write data and read/write strobes the data memory consumes, then waits for the memory acknowledge. Returns aligned, sign- or zero-extended load data (or an exception code) to the pipeline over a valid/ready handshake.

## Interface
Parameters:
- TIMEOUT, 16, max cycles spent in ISSUE waiting for mem_ack before a bus-error response (range 1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept a request
- req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low-order bits used for sh/sb)
- req_rd  in  5  destination register tag, echoed on response
- rsp_valid  out  1  response valid
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and exceptions
- rsp_rd  out  5  echoed tag
- rsp_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout
- mem_addr  out  32  byte address to data memory
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit n = bits [8n+7:8n]
- mem_we / mem_re  out  1 each  write / read strobes
- mem_rdata  in  32  full word read from memory
- mem_ack  in  1  memory completed the access this cycle

## Operation
- States: IDLE, ISSUE, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid, latch op/addr/wdata/rd. Misaligned (lw/sw addr[1:0]≠0; lh/lhu/sh addr[0]≠0) → RESP with exc 01 (loads) or 10 (stores), no memory access. Otherwise → ISSUE, timeout counter cleared.
- ISSUE: mem_addr = latched addr; mem_we = store, mem_re = load, both held until mem_ack or timeout.
  - mem_be: sw 1111; sh addr[1] ? 1100 : 0011; sb 0001 << addr[1:0]; loads 0000.
  - mem_wdata: sw raw; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
- On mem_ack: loads select lane (byte by addr[1:0], half by addr[1]), sign-extend lb/lh, zero-extend lbu/lhu, lw whole word; capture into rsp_rdata; → RESP, strobes drop the same edge.
- Timeout: counter increments each ISSUE cycle without ack; when it reaches TIMEOUT → RESP, exc 11, rdata 0, strobes drop. A mem_ack in the same cycle as expiry wins (normal completion).
- RESP: rsp_valid = 1, outputs stable until rsp_ready; on rsp_ready → IDLE.
- mem_ack outside ISSUE is ignored.

## Timing
- All outputs registered except req_ready (decoded from state).
- Reset (async, level): state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_rd 0, rsp_exc 00, mem_addr 0, mem_wdata 0, mem_be 0, mem_we 0, mem_re 0, counter 0.
- Reset mid-ISSUE: strobes drop immediately (asynchronously); transaction discarded, no response.
- Aligned access, request accepted at edge 0: strobes high cycle 1; mem_ack in cycle 1 → rsp_valid high cycle 2. Minimum latency 2 cycles, throughput one request per 3 cycles with rsp_ready held high.
- Misaligned: rsp_valid high the cycle after acceptance; mem_we/mem_re never assert.
- Timeout: rsp_valid high exactly TIMEOUT+1 cycles after acceptance.

## Test plan
- lw 0x0000_0010, memory acks cycle 1 with 0x8899_AABB → mem_re 1, be 0000, rsp_rdata 0x8899_AABB, exc 00, rsp_valid in cycle 2.
- lb 0x13 / lbu 0x13 with word 0x80FF_7F01 → rdata 0xFFFF_FF80 / 0x0000_0080; lh 0x12 → 0xFFFF_80FF.
- sb 0x0000_0006 wdata 0x1234_56AB → be 0100, mem_wdata 0xABAB_ABAB, mem_we 1 until ack; sh 0x6 wdata 0x0000_BEEF → be 1100, wdata 0xBEEF_BEEF.
- lw 0x2 → exc 01, no mem_re; sh 0x5 → exc 10, no mem_we; rdata 0.
- Withhold mem_ack, TIMEOUT=16 → exc 11 at cycle 17; ack on cycle 16 instead → normal completion.
- Hold rsp_ready 0 for 5 cycles → response stable, req_ready 0; pull reset low mid-ISSUE → strobes low immediately, no rsp_valid after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: data-memory initiator for the MEM stage.
// Ports: req_* (pipeline in), rsp_* (pipeline out), mem_* (data memory).
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic [1:0]  rsp_exc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [1:0]  rsp_exc_q, rsp_exc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;

  logic        req_st;
  logic        req_mis;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic        op_st;
  logic [31:0] ld_sh;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign req_st = req_op[2] & (|req_op[1:0]);
  assign op_st  = op_q[2] & (|op_q[1:0]);

  always_comb begin
    req_mis = 1'b0;
    unique case (1'b1)
      (req_op == OP_LW) || (req_op == OP_SW):
        req_mis = |req_addr[1:0];
      (req_op == OP_LH) || (req_op == OP_LHU) ||
      (req_op == OP_SH):
        req_mis = req_addr[0];
      default: req_mis = 1'b0;
    endcase
  end

  always_comb begin
    req_be = 4'b0000;
    req_wd = req_wdata;
    unique case (1'b1)
      req_op == OP_SW: req_be = 4'b1111;
      req_op == OP_SH: begin
        req_be = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{req_wdata[15:0]}};
      end
      req_op == OP_SB: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      default: req_be = 4'b0000;
    endcase
  end

  // Lane select uses the latched address still on mem_addr.
  assign ld_sh = mem_rdata >> {mem_addr_q[1:0], 3'b000};
  assign ld_b  = ld_sh[7:0];
  assign ld_h  = mem_addr_q[1] ? mem_rdata[31:16]
                               : mem_rdata[15:0];

  always_comb begin
    case (op_q)
      OP_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      OP_LHU:  ld_data = {16'h0, ld_h};
      OP_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      OP_LBU:  ld_data = {24'h0, ld_b};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_exc_d   = rsp_exc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          rsp_rd_d    = req_rd;
          rsp_rdata_d = 32'h0;
          if (req_mis) begin
            rsp_valid_d = 1'b1;
            rsp_exc_d   = req_st ? 2'b10 : 2'b01;
            state_d     = RESP;
          end else begin
            rsp_exc_d   = 2'b00;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wd;
            mem_be_d    = req_be;
            mem_we_d    = req_st;
            mem_re_d    = ~req_st;
            cnt_d       = 8'h0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        // An ack in the expiry cycle still completes normally.
        if (mem_ack || cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_re_d    = 1'b0;
          mem_be_d    = 4'b0000;
          state_d     = RESP;
          if (mem_ack) begin
            rsp_exc_d   = 2'b00;
            rsp_rdata_d = op_st ? 32'h0 : ld_data;
          end else begin
            rsp_exc_d   = 2'b11;
            rsp_rdata_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      cnt_q       <= 8'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_rd_q    <= 5'h0;
      rsp_exc_q   <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_exc_q   <= rsp_exc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_exc   = rsp_exc_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu.
// Drives and samples 1ns after each rising edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_exc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_rd    (rsp_rd),
    .rsp_exc   (rsp_exc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0]  op,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [4:0]  rd);
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    mem_rdata = d;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic load(input string tag,
                      input logic [2:0]  op,
                      input logic [31:0] a,
                      input logic [31:0] w,
                      input logic [31:0] exp);
    send(op, a, 32'h0, 5'd3);
    check({tag, " re"}, 32'(mem_re), 32'h1);
    ack(w);
    check({tag, " vld"}, 32'(rsp_valid), 32'h1);
    check({tag, " data"}, rsp_rdata, exp);
    drain();
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_rd    = 5'h0;
    rsp_ready = 1'b0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    step();
    check("rst ready", 32'(req_ready), 32'h1);
    check("rst vld", 32'(rsp_valid), 32'h0);
    check("rst data", rsp_rdata, 32'h0);
    check("rst exc", 32'(rsp_exc), 32'h0);
    check("rst strb", {30'h0, mem_we, mem_re},
          32'h0);
    check("rst be", 32'(mem_be), 32'h0);
    check("rst addr", mem_addr, 32'h0);
    check("rst wd", mem_wdata, 32'h0);
    step();
    reset = 1'b1;
    step();

    // lw, ack in cycle 1
    send(3'b000, 32'h10, 32'h0, 5'd9);
    check("lw re", 32'(mem_re), 32'h1);
    check("lw we", 32'(mem_we), 32'h0);
    check("lw be", 32'(mem_be), 32'h0);
    check("lw addr", mem_addr, 32'h10);
    check("lw rdy", 32'(req_ready), 32'h0);
    ack(32'h8899_AABB);
    check("lw vld", 32'(rsp_valid), 32'h1);
    check("lw data", rsp_rdata, 32'h8899_AABB);
    check("lw exc", 32'(rsp_exc), 32'h0);
    check("lw rd", 32'(rsp_rd), 32'd9);
    check("lw re off", 32'(mem_re), 32'h0);
    drain();
    check("lw done", 32'(rsp_valid), 32'h0);
    check("lw idle", 32'(req_ready), 32'h1);

    load("lb13", 3'b011, 32'h13, 32'h80FF_7F01,
         32'hFFFF_FF80);
    load("lbu13", 3'b100, 32'h13, 32'h80FF_7F01,
         32'h0000_0080);
    load("lh12", 3'b001, 32'h12, 32'h80FF_7F01,
         32'hFFFF_80FF);
    load("lhu12", 3'b010, 32'h12, 32'h80FF_7F01,
         32'h0000_80FF);
    load("lb11", 3'b011, 32'h11, 32'h80FF_7F01,
         32'h0000_007F);
    load("lh10", 3'b001, 32'h10, 32'h80FF_7F01,
         32'h0000_7F01);

    // sb, ack withheld one cycle
    send(3'b111, 32'h6, 32'h1234_56AB, 5'd1);
    check("sb be", 32'(mem_be), 32'h4);
    check("sb wd", mem_wdata, 32'hABAB_ABAB);
    check("sb we", 32'(mem_we), 32'h1);
    check("sb re", 32'(mem_re), 32'h0);
    step();
    check("sb we held", 32'(mem_we), 32'h1);
    ack(32'hFFFF_FFFF);
    check("sb vld", 32'(rsp_valid), 32'h1);
    check("sb data", rsp_rdata, 32'h0);
    check("sb exc", 32'(rsp_exc), 32'h0);
    check("sb we off", 32'(mem_we), 32'h0);
    drain();

    send(3'b110, 32'h6, 32'h0000_BEEF, 5'd2);
    check("sh be", 32'(mem_be), 32'hC);
    check("sh wd", mem_wdata, 32'hBEEF_BEEF);
    check("sh we", 32'(mem_we), 32'h1);
    ack(32'h0);
    drain();

    send(3'b101, 32'h8, 32'hDEAD_BEEF, 5'd2);
    check("sw be", 32'(mem_be), 32'hF);
    check("sw wd", mem_wdata, 32'hDEAD_BEEF);
    ack(32'h0);
    drain();

    // misaligned
    send(3'b000, 32'h2, 32'h0, 5'd4);
    check("lw2 vld", 32'(rsp_valid), 32'h1);
    check("lw2 exc", 32'(rsp_exc), 32'h1);
    check("lw2 data", rsp_rdata, 32'h0);
    check("lw2 re", 32'(mem_re), 32'h0);
    drain();
    send(3'b110, 32'h5, 32'hFFFF, 5'd4);
    check("sh5 vld", 32'(rsp_valid), 32'h1);
    check("sh5 exc", 32'(rsp_exc), 32'h2);
    check("sh5 we", 32'(mem_we), 32'h0);
    check("sh5 data", rsp_rdata, 32'h0);
    drain();

    // timeout: response expected in cycle 17
    send(3'b000, 32'h20, 32'h0, 5'd5);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 16)
        check("to re16", 32'(mem_re), 32'h1);
    end
    check("to cycle", 32'(cyc), 32'd17);
    check("to exc", 32'(rsp_exc), 32'h3);
    check("to data", rsp_rdata, 32'h0);
    check("to re off", 32'(mem_re), 32'h0);
    drain();

    // ack exactly at expiry wins
    send(3'b000, 32'h24, 32'h0, 5'd6);
    repeat (15) step();
    check("ack16 vld0", 32'(rsp_valid), 32'h0);
    check("ack16 re", 32'(mem_re), 32'h1);
    ack(32'h1122_3344);
    check("ack16 vld", 32'(rsp_valid), 32'h1);
    check("ack16 exc", 32'(rsp_exc), 32'h0);
    check("ack16 data", rsp_rdata, 32'h1122_3344);
    drain();

    // backpressure
    send(3'b000, 32'h4, 32'h0, 5'd7);
    ack(32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      check("bp vld", 32'(rsp_valid), 32'h1);
      check("bp data", rsp_rdata, 32'hCAFE_F00D);
      check("bp rd", 32'(rsp_rd), 32'd7);
      check("bp rdy", 32'(req_ready), 32'h0);
      step();
    end
    drain();
    check("bp done", 32'(rsp_valid), 32'h0);

    // reset mid-ISSUE
    send(3'b111, 32'h1, 32'hAA, 5'd8);
    check("mr we", 32'(mem_we), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mr we off", 32'(mem_we), 32'h0);
    check("mr be off", 32'(mem_be), 32'h0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mr no rsp", 32'(rsp_valid), 32'h0);
      check("mr rdy", 32'(req_ready), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
